// File: rtl/uart_send_pkg.sv
// Shared constants and helpers for the UART transmitter.
package uart_send_pkg;

    // One start bit, eight data bits, one stop bit
    localparam int unsigned FRAME_BITS = 10;

    // Bit-counter value of the stop bit
    localparam logic [3:0] BIT_STOP = 4'd9;

    // Bit-counter value of the last data bit (D7)
    localparam logic [3:0] BIT_LAST_DATA = 4'd8;

    // Clock cycles per bit; integer truncation is intended
    function automatic int baud_div(input int clk_hz, input int bps);
        return clk_hz / bps;
    endfunction

endpackage

// File: rtl/uart_send.sv
// 8N1 UART transmitter.
// Accepts one byte per request and shifts it out LSB first,
// framed by a start bit and a stop bit.
module uart_send
    import uart_send_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int UART_BPS = 115200
)(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       uart_en_i,
    input  logic [7:0] uart_din_i,
    output logic       uart_tx_busy_o,
    output logic       uart_txd_o
);

    localparam int BPS_CNT = baud_div(CLK_FREQ, UART_BPS);
    localparam int BAUD_W  = $clog2(BPS_CNT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BPS_CNT - 1);

    // The state register doubles as the tx_active flag: IDLE = 0
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            r_state;
    logic [BAUD_W-1:0] r_baud_cnt;
    logic [3:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic              r_txd;

    state_t            w_state_next;
    logic [BAUD_W-1:0] w_baud_next;
    logic [3:0]        w_bit_next;
    logic [7:0]        w_shift_next;
    logic              w_txd_next;

    // State, counters, latched byte and line flop; reset idles the line high
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= 8'h00;
            r_txd      <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_next;
            r_bit_cnt  <= w_bit_next;
            r_shift    <= w_shift_next;
            r_txd      <= w_txd_next;
        end
    end

    // Next-state logic: start on request, advance one bit per baud period,
    // release the line after the stop bit
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud_cnt;
        w_bit_next   = r_bit_cnt;
        w_shift_next = r_shift;
        w_txd_next   = r_txd;

        case (r_state)
            IDLE: begin
                w_txd_next = 1'b1;
                if (uart_en_i) begin
                    w_state_next = SEND;
                    w_shift_next = uart_din_i;
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                    w_txd_next   = 1'b0;
                end
            end
            SEND: begin
                // Requests and din are ignored here; the byte stays latched
                if (r_baud_cnt == BAUD_LAST) begin
                    w_baud_next = '0;
                    if (r_bit_cnt == BIT_STOP) begin
                        w_state_next = IDLE;
                        w_bit_next   = '0;
                        w_txd_next   = 1'b1;
                    end else begin
                        w_bit_next = r_bit_cnt + 4'd1;
                        // Counter value k (0..7) is followed by data bit Dk;
                        // after D7 comes the stop bit
                        if (r_bit_cnt == BIT_LAST_DATA) begin
                            w_txd_next = 1'b1;
                        end else begin
                            w_txd_next = r_shift[r_bit_cnt[2:0]];
                        end
                    end
                end else begin
                    w_baud_next = r_baud_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_txd_next   = 1'b1;
            end
        endcase
    end

    // Busy is combinational so a requester sees it rise in the cycle it asserts en
    assign uart_tx_busy_o = (r_state == SEND) | uart_en_i;
    assign uart_txd_o     = r_txd;

endmodule

// File: tb/tb_uart_send.sv
// Self-checking bench for uart_send at default parameters (434 cycles per bit).
`timescale 1ns/1ps
module tb_uart_send;

    localparam int BIT_CYC   = 50000000 / 115200;
    localparam int FRAME_CYC = 10 * BIT_CYC;

    logic       clk_i;
    logic       rst_n_i;
    logic       uart_en_i;
    logic [7:0] uart_din_i;
    logic       uart_tx_busy_o;
    logic       uart_txd_o;

    int errors = 0;
    int checks = 0;
    logic [7:0] got_q[$];

    uart_send dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .uart_en_i      (uart_en_i),
        .uart_din_i     (uart_din_i),
        .uart_tx_busy_o (uart_tx_busy_o),
        .uart_txd_o     (uart_txd_o)
    );

    initial clk_i = 1'b0;
    always #10 clk_i = ~clk_i;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Issue one byte and watch the whole frame.
    // disturb: toggle en with din=FF mid-frame. abort_at: cycle index to reset at (-1 = none).
    task automatic send_frame(input logic [7:0] b, input bit disturb, input int abort_at);
        int n;
        int bad;
        int busy_n;
        logic [9:0] frame;
        logic [9:0] seen;
        frame  = {1'b1, b, 1'b0};
        bad    = 0;
        busy_n = 0;
        seen   = '0;
        n = 0;
        while (uart_tx_busy_o !== 1'b0 && n < 10000) begin
            @(negedge clk_i);
            n++;
        end
        chk("idle_before_req", {31'd0, uart_tx_busy_o}, 32'd0);
        uart_din_i = b;
        uart_en_i  = 1'b1;
        #1;
        chk("busy_same_cycle", {31'd0, uart_tx_busy_o}, 32'd1);
        @(negedge clk_i);
        uart_en_i  = 1'b0;
        uart_din_i = 8'($urandom);
        for (n = 0; n < FRAME_CYC; n++) begin
            if (n > 0) @(negedge clk_i);
            if (disturb && n >= 1000 && n < 1010) begin
                uart_en_i  = (n % 2 == 0);
                uart_din_i = 8'hFF;
            end else if (disturb && n == 1010) begin
                uart_en_i = 1'b0;
            end
            if (n == abort_at) begin
                rst_n_i = 1'b0;
                #1;
                chk("txd_high_on_reset", {31'd0, uart_txd_o}, 32'd1);
                chk("busy_in_reset", {31'd0, uart_tx_busy_o}, {31'd0, uart_en_i});
                repeat (2) @(negedge clk_i);
                chk("txd_held_in_reset", {31'd0, uart_txd_o}, 32'd1);
                rst_n_i = 1'b1;
                @(negedge clk_i);
                chk("idle_after_release", {30'd0, uart_tx_busy_o, uart_txd_o}, 32'd1);
                $display("frame %02h aborted by reset at cycle %0d", b, n);
                return;
            end
            if (uart_txd_o !== frame[n / BIT_CYC]) bad++;
            if (uart_tx_busy_o === 1'b1) busy_n++;
            if (n % BIT_CYC == BIT_CYC / 2) seen[n / BIT_CYC] = uart_txd_o;
        end
        @(negedge clk_i);
        chk("frame_bits", {22'd0, seen}, {22'd0, frame});
        chk("txd_cycle_errors", bad, 0);
        chk("busy_cycles", busy_n, FRAME_CYC);
        chk("end_idle", {30'd0, uart_tx_busy_o, uart_txd_o}, 32'd1);
        got_q.push_back(seen[8:1]);
        $display("frame sent=%02h decoded=%02h bad_cycles=%0d busy_cycles=%0d", b, seen[8:1], bad, busy_n);
    endtask

    initial begin
        string msg;
        logic [7:0] rb;
        int quiet;
        msg        = "Hello World!";
        rst_n_i    = 1'b0;
        uart_en_i  = 1'b0;
        uart_din_i = 8'h00;

        // Reset behaviour
        repeat (2) @(negedge clk_i);
        chk("rst_txd", {31'd0, uart_txd_o}, 32'd1);
        chk("rst_busy_en0", {31'd0, uart_tx_busy_o}, 32'd0);
        uart_en_i  = 1'b1;
        uart_din_i = 8'h3C;
        #1;
        chk("rst_busy_en1", {31'd0, uart_tx_busy_o}, 32'd1);
        repeat (2) @(negedge clk_i);
        chk("rst_no_start", {31'd0, uart_txd_o}, 32'd1);
        uart_en_i = 1'b0;
        rst_n_i   = 1'b1;
        @(negedge clk_i);
        chk("post_rst_idle", {30'd0, uart_tx_busy_o, uart_txd_o}, 32'd1);
        $display("reset checks done");

        // Single byte 'H'
        send_frame(8'h48, 1'b0, -1);

        // Stream of 12 bytes, requester waits for busy low before each
        got_q.delete();
        for (int i = 0; i < msg.len(); i++) send_frame(msg[i], 1'b0, -1);
        chk("stream_len", got_q.size(), msg.len());
        for (int i = 0; i < msg.len() && i < got_q.size(); i++)
            chk("stream_byte", {24'd0, got_q[i]}, {24'd0, msg[i]});

        // One random byte
        rb = 8'($urandom_range(0, 255));
        send_frame(rb, 1'b0, -1);

        // Ignored mid-frame request, then no extra frame
        send_frame(8'h55, 1'b1, -1);
        quiet = 0;
        for (int i = 0; i < 2 * BIT_CYC; i++) begin
            @(negedge clk_i);
            if (uart_txd_o !== 1'b1 || uart_tx_busy_o !== 1'b0) quiet++;
        end
        chk("no_extra_frame", quiet, 0);
        $display("idle after ignored request: non-idle cycles=%0d", quiet);

        // Reset during data bit 3 (frame bit 4), then send 0xA5
        send_frame(8'($urandom_range(0, 255)), 1'b0, 4 * BIT_CYC + 100);
        send_frame(8'hA5, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_send.md
UART_SEND -- requirements
Module: uart_send

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter UART_BPS, default 115200, line baud rate in bit/s.
REQ-003 SHALL have port clk_i, input, 1, system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port uart_en_i, input, 1, send request: level-sampled; a 1 while idle starts a frame.
REQ-006 SHALL have port uart_din_i, input, 8, byte to send; sampled on the start edge.
REQ-007 SHALL have port uart_tx_busy_o, output, 1, transmitter busy / not ready.
REQ-008 SHALL have port uart_txd_o, output, 1, serial TX line; idle high.

Function
REQ-009 SHALL define local constant BPS_CNT = CLK_FREQ / UART_BPS, using integer truncation (434 at defaults).
REQ-010 SHALL size the baud counter as $clog2(BPS_CNT) bits.
REQ-011 SHALL size the bit counter as 4 bits, counting 0..9.
REQ-012 SHALL use two states: IDLE and SEND, held in internal flag tx_active (0 = IDLE).
REQ-013 Start edge: in IDLE, a rising clk_i edge with uart_en_i=1 SHALL perform all of the following:
  - latch uart_din_i into the shift register;
  - set tx_active=1;
  - clear the baud counter and the bit counter;
  - drive uart_txd_o=0 (start bit) from that edge.
REQ-014 Frame format SHALL be 10 bits in this order:
  - start bit 0;
  - data bits D0..D7, LSB first;
  - stop bit 1.
  - Each bit is held for exactly BPS_CNT clk_i cycles.
REQ-015 Bit advance: when the baud counter reaches BPS_CNT-1, it SHALL wrap to 0, the bit counter SHALL increment, and uart_txd_o SHALL take the next bit value on that same edge.
REQ-016 Frame end: when the stop-bit period expires (bit counter 9, baud counter BPS_CNT-1), the block SHALL do all of the following on that edge:
  - clear tx_active;
  - hold uart_txd_o=1;
  - return to IDLE.
  - Total frame length is 10*BPS_CNT cycles.
REQ-017 uart_tx_busy_o SHALL be combinational: tx_active OR uart_en_i.
  - Rationale: a requester that sees busy=0 and raises en sees busy=1 before its next edge, so it never double-issues.
REQ-018 While in SEND, uart_en_i and uart_din_i SHALL be ignored; the latched byte SHALL stay unchanged.
REQ-019 Back-to-back: uart_en_i=1 on the first IDLE edge after a frame end SHALL start the next frame; no idle cycles are required.
REQ-020 uart_txd_o SHALL be driven from a flop (glitch-free) and SHALL be 1 whenever the block is in IDLE.

Reset
REQ-021 While rst_n_i=0, the block SHALL immediately hold the following:
  - tx_active=0;
  - baud counter = 0 and bit counter = 0;
  - shift register = 0x00;
  - uart_txd_o=1.
  - uart_tx_busy_o then equals uart_en_i.
REQ-022 Reset asserted mid-frame SHALL abort the frame and return the line high at once; no partial stop bit is sent.
REQ-023 After reset release, the first edge with uart_en_i=1 SHALL start a fresh frame per REQ-013.

Structure
REQ-024 SHALL be a single module; no shared package is needed, and BPS_CNT and the state encoding SHALL be local parameters.
REQ-025 No sub-module is required; the baud counter, bit counter and shift/mux logic SHALL sit inline in uart_send.

Verification
REQ-026 Reset checks:
  - hold rst_n_i=0 for 2 cycles -> uart_txd_o=1;
  - with en=0 -> busy=0;
  - with en=1 -> busy=1 and no frame starts.
REQ-027 Single byte: en=1 for one cycle with din=0x48 ('H') -> uart_txd_o sequence 0,0,0,0,1,0,0,1,0,1, each bit 434 cycles (8680 ns at 20 ns clock), then idle high.
REQ-028 Busy timing:
  - busy=1 in the same cycle en is raised;
  - busy stays 1 for exactly 4340 cycles after the start edge;
  - busy drops to 0 on the frame-end edge.
REQ-029 String stream: a requester issuing en whenever busy=0 with "Hello World!" (12 bytes) -> 12 contiguous frames decode to exactly "Hello World!", with no skipped or duplicated byte.
REQ-030 Ignored request: toggle en and din=0xFF mid-frame of byte 0x55 -> the frame still carries 0x55 and no extra frame follows.
REQ-031 Mid-frame reset: assert rst_n_i during data bit 3 -> txd=1 immediately; after release, a new byte 0xA5 is sent correctly.
